// File: rtl/pmu_quota_sched.sv
// Time-multiplexed quota controller: sweeps each core's counter mask through one
// shared accumulator, raises sticky per-core interrupts, and handles replenish windows.
module pmu_quota_sched #(
  parameter int REG_WIDTH  = 32,
  parameter int N_COUNTERS = 9,
  parameter int N_CORES    = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            softrst_i,
  input  logic                            en_i,
  input  logic [N_COUNTERS*REG_WIDTH-1:0] counter_value_i,
  input  logic [N_CORES*N_COUNTERS-1:0]   quota_mask_i,
  input  logic [N_CORES*REG_WIDTH-1:0]    quota_limit_i,
  input  logic [REG_WIDTH-1:0]            period_i,
  output logic                            period_clear_o,
  output logic [N_CORES-1:0]              intr_quota_o,
  output logic                            busy_o,
  output logic [$clog2(N_CORES)-1:0]      core_idx_o
);

  localparam int SUM_W = $clog2(N_COUNTERS) + REG_WIDTH;
  localparam int CIW   = $clog2(N_CORES);
  localparam int KIW   = $clog2(N_COUNTERS);
  localparam logic [CIW-1:0] LAST_CORE = CIW'(N_CORES - 1);
  localparam logic [KIW-1:0] LAST_CNT  = KIW'(N_COUNTERS - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, ACCUM, COMPARE} state_t;

  state_t                  state_q, state_d;
  logic [SUM_W-1:0]        sum_q, sum_d;
  logic [CIW-1:0]          core_q, core_d;
  logic [KIW-1:0]          cnt_q, cnt_d;
  logic [REG_WIDTH-1:0]    win_q, win_d;
  logic [N_CORES-1:0]      intr_q, intr_d;
  logic                    pclr_q, pclr_d;
  logic [N_COUNTERS-1:0]   mask_q, mask_d;

  logic [REG_WIDTH-1:0]    cnt_arr  [N_COUNTERS];
  logic [N_COUNTERS-1:0]   mask_arr [N_CORES];
  logic [REG_WIDTH-1:0]    lim_arr  [N_CORES];

  always_comb begin
    for (int unsigned k = 0; k < N_COUNTERS; k++)
      cnt_arr[k] = counter_value_i[k*REG_WIDTH +: REG_WIDTH];
    for (int unsigned c = 0; c < N_CORES; c++) begin
      mask_arr[c] = quota_mask_i[c*N_COUNTERS +: N_COUNTERS];
      lim_arr[c]  = quota_limit_i[c*REG_WIDTH +: REG_WIDTH];
    end
  end

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    core_d  = core_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    intr_d  = intr_q;
    pclr_d  = 1'b0;
    mask_d  = mask_q;
    if (softrst_i) begin
      state_d = IDLE;
      sum_d   = '0;
      core_d  = '0;
      cnt_d   = '0;
      win_d   = '0;
      intr_d  = '0;
    end else if (!en_i) begin
      state_d = IDLE;
      sum_d   = '0;
      cnt_d   = '0;
      core_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = CLEAR;
          core_d  = '0;
        end
        CLEAR: begin
          sum_d   = '0;
          cnt_d   = '0;
          mask_d  = mask_arr[core_q];
          state_d = ACCUM;
        end
        ACCUM: begin
          // A mask edit restarts the current core so no mixed-mask sum is ever compared
          if (mask_arr[core_q] != mask_q) begin
            state_d = CLEAR;
          end else begin
            if (mask_q[cnt_q])
              sum_d = sum_q + SUM_W'(cnt_arr[cnt_q]);
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_CNT)
              state_d = COMPARE;
          end
        end
        COMPARE: begin
          if (sum_q > SUM_W'(lim_arr[core_q]))
            intr_d[core_q] = 1'b1;
          core_d  = (core_q == LAST_CORE) ? '0 : core_q + 1'b1;
          state_d = CLEAR;
        end
        default: state_d = IDLE;
      endcase
      // Window end overrides the FSM step above, so a same-cycle compare set is dropped
      if (period_i != '0) begin
        if (win_q >= period_i - 1'b1) begin
          win_d   = '0;
          pclr_d  = 1'b1;
          intr_d  = '0;
          state_d = CLEAR;
          core_d  = '0;
        end else begin
          win_d = win_q + 1'b1;
        end
      end else begin
        win_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      sum_q   <= '0;
      core_q  <= '0;
      cnt_q   <= '0;
      win_q   <= '0;
      intr_q  <= '0;
      pclr_q  <= 1'b0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      core_q  <= core_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
      intr_q  <= intr_d;
      pclr_q  <= pclr_d;
      mask_q  <= mask_d;
    end
  end

  assign period_clear_o = pclr_q;
  assign intr_quota_o   = intr_q;
  assign busy_o         = (state_q != IDLE);
  assign core_idx_o     = core_q;

endmodule
